// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters (req0 = ALU, req1 = load). After reset the block first walks
// through registers 1 .. 2**ADDR_W-1, writing zero to one register per
// cycle (CLEAR). It then arbitrates between the requesters (RUN).
//
// Arbitration rules in RUN:
//   - A single valid requester is granted in the same cycle.
//   - When both are valid, they alternate (round-robin). The winner of
//     the previous both-valid cycle loses this one.
//
// The accepted write appears on the register-file port one cycle later.
// A write to register 0 is accepted and dropped; no strobe is issued.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   reqN_valid/addr/data    requester N write request (N = 0, 1)
//   reqN_ready              requester N accepted this cycle (combinational)
//   rf_write                register-file write strobe (registered)
//   rf_w_addr, rf_d_in      register-file write address / data (held when idle)
//   busy                    clear sequence in progress or in reset
//   conflict_cnt            saturating count of RUN cycles with both valid
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              busy,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  // 1: req1 won the last both-valid cycle, so req0 wins the next one.
  logic              last_grant;
  logic              grant0, grant1;
  logic              both_valid;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  assign both_valid = req0_valid & req1_valid;

  // Next-state and grant logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    grant0      = 1'b0;
    grant1      = 1'b0;

    unique case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Grants are suppressed while reset is high. Requests presented
        // during reset are dropped.
        if (!reset) begin
          grant0 = req0_valid & (~req1_valid |  last_grant);
          grant1 = req1_valid & (~req0_valid | ~last_grant);
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign accept   = grant0 | grant1;
  assign acc_addr = grant1 ? req1_addr : req0_addr;
  assign acc_data = grant1 ? req1_data : req0_data;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = reset | (state == CLEAR);

  // State, clear pointer, arbitration history, output write port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge, whatever the
    // statement order.
    if (reset) begin
      state        <= CLEAR;
      clr_ptr      <= ADDR_W'(1);
      rf_write     <= 1'b0;
      rf_w_addr    <= '0;
      rf_d_in      <= '0;
      conflict_cnt <= '0;
      last_grant   <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;

      if (state == CLEAR) begin
        rf_write  <= 1'b1;
        rf_w_addr <= clr_ptr;
        rf_d_in   <= '0;
      end else if (accept && (acc_addr != '0)) begin
        rf_write  <= 1'b1;
        rf_w_addr <= acc_addr;
        rf_d_in   <= acc_data;
      end else begin
        // Address and data keep their last values. Register 0 writes end up
        // here and are consumed silently.
        rf_write <= 1'b0;
      end

      if ((state == RUN) && both_valid) begin
        last_grant <= grant1;
        if (conflict_cnt != 8'hFF) begin
          conflict_cnt <= conflict_cnt + 8'd1;
        end
      end
    end
  end

endmodule
